// File: rtl/next_pc_control.sv
// next_pc_control: next-PC sequencing (fetch, branch redirect, stall, HALT drain).
// Optional macro PERF_CNT_EN adds a saturating RedirectCount output.
module next_pc_control #(
  parameter logic [15:0] PC_STEP      = 16'd2,
  parameter logic [3:0]  HALT_OPCODE  = 4'hF,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] PC,
  input  logic [15:0] Instr,
  input  logic        BranchTaken,
  input  logic [15:0] BranchTarget,
  input  logic        LoadUseStall,
  output logic [15:0] NewPC,
  output logic        StopPC,
  output logic        FlushIF,
  output logic        Halt
`ifdef PERF_CNT_EN
  ,
  output logic [15:0] RedirectCount
`endif
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic halt_q, halt_d;
  logic is_halt, redirect, hold;
  logic unused_instr;
  assign unused_instr = ^Instr[11:0];
  assign is_halt = Instr[15:12] == HALT_OPCODE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    halt_d  = halt_q;
    case (state_q)
      RUN:
        if (!BranchTaken && !LoadUseStall && is_halt) begin
          state_d = DRAIN;
          cnt_d   = CNT_INIT;
        end
      DRAIN:
        if (BranchTaken) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = HALTED;
          halt_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      default: ;
    endcase
  end
  // a redirect is honoured everywhere except once halted; it overrides any hold
  always_comb begin
    redirect = BranchTaken && state_q != HALTED;
    hold     = state_q != RUN || LoadUseStall || is_halt;
    NewPC    = redirect ? BranchTarget : hold ? PC : PC + PC_STEP;
    StopPC   = !redirect && hold;
    FlushIF  = redirect;
    Halt     = halt_q;
  end
`ifdef PERF_CNT_EN
  logic [15:0] redirect_count_q, redirect_count_d;
  always_comb
    redirect_count_d = (FlushIF && ~&redirect_count_q) ? redirect_count_q + 16'd1 : redirect_count_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) redirect_count_q <= '0;
    else redirect_count_q <= redirect_count_d;
  assign RedirectCount = redirect_count_q;
`endif
endmodule

// File: tb/tb_next_pc_control.sv
// tb_next_pc_control: directed stimulus, behavioural model compared every cycle,
// plus literal expectations. Define PERF_CNT_EN to exercise the redirect counter.
module tb_next_pc_control;
  logic clk, rst;
  logic [15:0] PC, Instr, BranchTarget, NewPC;
  logic BranchTaken, LoadUseStall, StopPC, FlushIF, Halt;
`ifdef PERF_CNT_EN
  logic [15:0] RedirectCount;
`endif
  int checks = 0, errors = 0;

  next_pc_control dut (
    .clk(clk), .rst(rst), .PC(PC), .Instr(Instr), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .LoadUseStall(LoadUseStall), .NewPC(NewPC),
    .StopPC(StopPC), .FlushIF(FlushIF), .Halt(Halt)
`ifdef PERF_CNT_EN
    , .RedirectCount(RedirectCount)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // model: drain progress counted in edges since HALT was detected
  bit m_drain, m_halted;
  int m_edges, m_cnt;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_drain = 0; m_halted = 0; m_edges = 0; m_cnt = 0;
    end else begin
      if (!m_halted && BranchTaken && m_cnt != 65535) m_cnt++;
      if (!m_halted) begin
        if (BranchTaken) m_drain = 0;
        else if (m_drain) begin
          m_edges++;
          if (m_edges == 4) begin m_halted = 1; m_drain = 0; end
        end else if (!LoadUseStall && Instr[15:12] == 4'hF) begin
          m_drain = 1; m_edges = 0;
        end
      end
    end

  always @(negedge clk) begin
    logic [15:0] e_pc;
    logic e_stop, e_flush;
    if (m_halted) begin e_pc = PC; e_stop = 1; e_flush = 0; end
    else if (BranchTaken) begin e_pc = BranchTarget; e_stop = 0; e_flush = 1; end
    else if (m_drain || LoadUseStall || Instr[15:12] == 4'hF) begin e_pc = PC; e_stop = 1; e_flush = 0; end
    else begin e_pc = PC + 16'd2; e_stop = 0; e_flush = 0; end
    chk("model NewPC", NewPC, e_pc);
    chk("model StopPC", {15'd0, StopPC}, {15'd0, e_stop});
    chk("model FlushIF", {15'd0, FlushIF}, {15'd0, e_flush});
    chk("model Halt", {15'd0, Halt}, {15'd0, m_halted});
`ifdef PERF_CNT_EN
    chk("model RedirectCount", RedirectCount, 16'(m_cnt));
`endif
  end

  task automatic step(input logic [15:0] pc, input logic [15:0] instr, input logic bt,
                      input logic [15:0] tgt, input logic lus);
    @(posedge clk);
    #1;
    PC = pc; Instr = instr; BranchTaken = bt; BranchTarget = tgt; LoadUseStall = lus;
    @(negedge clk);
  endtask

  initial begin
    rst = 0; PC = 16'h0010; Instr = 16'h1234; BranchTaken = 0; BranchTarget = 16'hDEAD; LoadUseStall = 0;
    #2 chk("reset Halt", {15'd0, Halt}, 16'd0);
    #6 rst = 1;
    // sequential fetch and wrap
    step(16'h0010, 16'h1234, 0, 16'hDEAD, 0);
    chk("seq NewPC", NewPC, 16'h0012);
    chk("seq StopPC", {15'd0, StopPC}, 16'd0);
    chk("seq FlushIF", {15'd0, FlushIF}, 16'd0);
    step(16'hFFFE, 16'h1234, 0, 16'hBEEF, 0);
    chk("wrap NewPC", NewPC, 16'h0000);
    // branch beats stall and wrong-path HALT
    step(16'h0050, 16'hF000, 1, 16'h0100, 1);
    chk("br NewPC", NewPC, 16'h0100);
    chk("br FlushIF", {15'd0, FlushIF}, 16'd1);
    chk("br StopPC", {15'd0, StopPC}, 16'd0);
    step(16'h0100, 16'h1234, 0, 16'h0000, 0);
    chk("br run NewPC", NewPC, 16'h0102);
    // load-use stall
    for (int i = 0; i < 2; i++) begin
      step(16'h0020, 16'h1234, 0, 16'h0000, 1);
      chk("stall NewPC", NewPC, 16'h0020);
      chk("stall StopPC", {15'd0, StopPC}, 16'd1);
    end
    step(16'h0020, 16'h1234, 0, 16'h0000, 0);
    chk("resume NewPC", NewPC, 16'h0022);
    // HALT drain
    step(16'h0030, 16'hF000, 0, 16'h0000, 0);
    chk("halt det StopPC", {15'd0, StopPC}, 16'd1);
    for (int j = 1; j <= 4; j++) begin
      step(16'h0030, 16'h1234, 0, 16'h0000, 0);
      chk("drain Halt", {15'd0, Halt}, 16'd0);
      chk("drain StopPC", {15'd0, StopPC}, 16'd1);
    end
    step(16'h0030, 16'h1234, 0, 16'h0000, 0);
    chk("halted Halt", {15'd0, Halt}, 16'd1);
    for (int j = 0; j < 10; j++) begin
      step(16'h0030, 16'h1234, 1'(j % 2), 16'h0444, 0);
      chk("halted sticky", {15'd0, Halt}, 16'd1);
      chk("halted NewPC", NewPC, 16'h0030);
    end
    #1 rst = 0;
    #1 chk("rst Halt", {15'd0, Halt}, 16'd0);
    #1 rst = 1;
    // drain aborted by a late branch
    step(16'h0040, 16'hF000, 0, 16'h0000, 0);
    step(16'h0040, 16'h1234, 0, 16'h0000, 0);
    step(16'h0040, 16'h1234, 1, 16'h0200, 0);
    chk("abort NewPC", NewPC, 16'h0200);
    chk("abort FlushIF", {15'd0, FlushIF}, 16'd1);
    for (int j = 0; j < 6; j++) begin
      step(16'h0200 + 16'(2 * j), 16'h1234, 0, 16'h0000, 0);
      chk("abort run StopPC", {15'd0, StopPC}, 16'd0);
      chk("abort no Halt", {15'd0, Halt}, 16'd0);
    end
    // async reset mid-drain
    step(16'h0060, 16'hF000, 0, 16'h0000, 0);
    step(16'h0060, 16'h1234, 0, 16'h0000, 0);
    chk("mid drain StopPC", {15'd0, StopPC}, 16'd1);
    #1 rst = 0;
    #1 chk("async rst Halt", {15'd0, Halt}, 16'd0);
    chk("async rst StopPC", {15'd0, StopPC}, 16'd0);
    #1 rst = 1;
`ifdef PERF_CNT_EN
    for (int j = 0; j < 3; j++) step(16'h0070, 16'h1234, 1, 16'h0300, 0);
    step(16'h0300, 16'h1234, 0, 16'h0000, 0);
    chk("perf 3", RedirectCount, 16'd3);
    #1 rst = 0;
    #1 chk("perf rst", RedirectCount, 16'd0);
    #1 rst = 1;
    for (int j = 0; j < 65536; j++) step(16'h0070, 16'h1234, 1, 16'h0300, 0);
    step(16'h0300, 16'h1234, 0, 16'h0000, 0);
    chk("perf sat", RedirectCount, 16'hFFFF);
`endif
    step(16'h0080, 16'h1234, 0, 16'h0000, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
